// File: rtl/dsc_serial_mul_pkg.sv
// Shared sizing for the deterministic stochastic-computing serial multiplier.
package dsc_serial_mul_pkg;

  localparam int DSC_WIDTH        = 6;
  localparam int DSC_PROD_W       = 2 * DSC_WIDTH;
  localparam int DSC_TOTAL_CYCLES = 1 << DSC_PROD_W;

  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/dsc_serial_mul_sng.sv
// Stochastic number generator: free-running level counter with wrap flag and
// unary comparator output (level > count).
module dsc_sng
  import dsc_serial_mul_pkg::*;
#(
  parameter int WIDTH = DSC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] level,
  output logic             sbit,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic [WIDTH-1:0] count_q, count_d;

  assign count_d = count_q + WIDTH'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign wrap  = &count_q;
  assign sbit  = level > count_q;

endmodule

// File: rtl/dsc_serial_mul.sv
// Serial clock-division DSC multiplier: stream B advances once per full sweep
// of stream A, so the ANDed popcount equals a*b after 2^(2*WIDTH) cycles.
module dsc_serial_mul
  import dsc_serial_mul_pkg::*;
#(
  parameter int WIDTH = DSC_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   z,
  output logic                 ov
);

  localparam int PW = prod_width(WIDTH);

  logic [WIDTH-1:0] a_q, b_q;
  logic             started_q;
  logic [PW-1:0]    z_q;
  logic             ov_q;

  logic [WIDTH-1:0] a_op, b_op;
  logic             en_run, en_b;
  logic             sa, sb, prod_bit;
  logic             wrap_a, wrap_b;
  logic [WIDTH-1:0] cnt_a, cnt_b;
  logic             unused_cnt;

  // First enabled cycle uses the live operands, later cycles the captured ones.
  assign a_op     = started_q ? a_q : a;
  assign b_op     = started_q ? b_q : b;
  assign en_run   = en & ~ov_q;
  assign en_b     = en_run & wrap_a;
  assign prod_bit = sa & sb;
  assign unused_cnt = ^{cnt_a, cnt_b};

  dsc_sng #(.WIDTH(WIDTH)) u_sng_a (
    .clk   (clk),
    .rst   (rst),
    .en    (en_run),
    .level (a_op),
    .sbit  (sa),
    .count (cnt_a),
    .wrap  (wrap_a)
  );

  dsc_sng #(.WIDTH(WIDTH)) u_sng_b (
    .clk   (clk),
    .rst   (rst),
    .en    (en_b),
    .level (b_op),
    .sbit  (sb),
    .count (cnt_b),
    .wrap  (wrap_b)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q       <= '0;
      b_q       <= '0;
      started_q <= 1'b0;
      z_q       <= '0;
      ov_q      <= 1'b0;
    end else if (en_run) begin
      if (!started_q) begin
        a_q       <= a;
        b_q       <= b;
        started_q <= 1'b1;
      end
      z_q <= z_q + PW'(prod_bit);
      // Last (ctr_a, ctr_b) pair: its bit lands on the same edge as ov.
      if (wrap_a && wrap_b) begin
        ov_q <= 1'b1;
      end
    end
  end

  assign z  = z_q;
  assign ov = ov_q;

endmodule

// File: tb/tb_dsc_serial_mul.sv
// Scoreboard bench for dsc_serial_mul: driver pushes expected products, a
// monitor pops and compares z and enabled-cycle latency when ov rises.
module tb_dsc_serial_mul;
  import dsc_serial_mul_pkg::*;

  localparam int W     = DSC_WIDTH;
  localparam int TOTAL = DSC_TOTAL_CYCLES;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en  = 1'b0;
  logic [W-1:0]   a   = '0;
  logic [W-1:0]   b   = '0;
  logic [2*W-1:0] z;
  logic           ov;

  dsc_serial_mul #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .a   (a),
    .b   (b),
    .z   (z),
    .ov  (ov)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   ecount   = 0;
  int   exp_q[$];
  logic ov_prev  = 1'b0;
  int   mon_exp;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (ov && !ov_prev) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected_ov: got ov with z=%0d, expected no pending op", z);
        end else begin
          mon_exp = exp_q.pop_front();
          check("sb_z", int'(z), mon_exp);
          check("sb_latency", ecount, TOTAL);
        end
      end
      ov_prev = ov;
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_op(input int av, input int bv, input int expz,
                        input bit do_reset, input bit toggle, input int chg_at);
    int cycles;
    bit done;
    if (do_reset) apply_reset();
    a = W'(av);
    b = W'(bv);
    ecount = 0;
    cycles = 0;
    done = 1'b0;
    exp_q.push_back(expz);
    while (!done) begin
      @(negedge clk);
      if (ov) begin
        done = 1'b1;
      end else if (cycles >= 20000) begin
        n_checks++;
        n_fail++;
        $display("FAIL timeout a=%0d b=%0d: got no ov after %0d cycles, expected ov", av, bv, cycles);
        void'(exp_q.pop_back());
        done = 1'b1;
      end else begin
        en = toggle ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (chg_at > 0 && ecount == chg_at) a = W'(5);
        @(posedge clk);
        if (en) ecount++;
        cycles++;
      end
    end
    en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  int pa[10] = '{36, 17, 12,  2, 62, 8,  31, 50, 25, 60};
  int pb[10] = '{ 9, 50, 11,  3, 63, 8,  32,  1, 40, 59};
  int pz[10] = '{324, 850, 132, 6, 3906, 64, 992, 50, 1000, 3540};

  initial begin
    rst = 1'b0;
    #12;
    check("reset_z", int'(z), 0);
    check("reset_ov", int'(ov), 0);

    run_op(63, 63, 3969, 1'b1, 1'b0, 0);
    en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("hold_ov", int'(ov), 1);
      check("hold_z", int'(z), 3969);
    end
    en = 1'b0;

    run_op(0, 45, 0, 1'b1, 1'b0, 0);
    run_op(45, 0, 0, 1'b1, 1'b0, 0);

    apply_reset();
    en = 1'b0;
    a = W'(1);
    b = W'(1);
    repeat (50) @(negedge clk);
    check("en_low_z", int'(z), 0);
    check("en_low_ov", int'(ov), 0);
    run_op(1, 1, 1, 1'b0, 1'b0, 0);

    for (int i = 0; i < 10; i++) run_op(pa[i], pb[i], pz[i], 1'b1, 1'b0, 0);

    run_op(20, 30, 600, 1'b1, 1'b1, 2000);

    apply_reset();
    a  = W'(40);
    b  = W'(40);
    en = 1'b1;
    repeat (1000) @(posedge clk);
    #2;
    check("abort_pre_z", int'(z), 640);
    check("abort_pre_ov", int'(ov), 0);
    rst = 1'b0;
    #1;
    check("abort_z", int'(z), 0);
    check("abort_ov", int'(ov), 0);
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b1;
    run_op(7, 8, 56, 1'b0, 1'b0, 0);

    repeat (3) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
